// File: rtl/des_pkg.sv
// Shared DES constants: S-box tables, datapath widths and the serial S-box FSM states.
package des_pkg;

  localparam int unsigned DES_SBOX_IN_W  = 6;
  localparam int unsigned DES_SBOX_OUT_W = 4;
  localparam int unsigned DES_HALF_W     = 32;
  localparam int unsigned DES_EXP_W      = 48;
  localparam int unsigned DES_NUM_SBOX   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_sbox_state_e;

  // Standard DES S1..S8. Box-major; inside a box, entry {row,col} with row 0 first.
  // Entry 0 of each box sits in the leftmost nibble of its 256-bit literal.
  localparam logic [0:7][0:63][3:0] DES_SBOX_T = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational S-box lane: selects a table by box index and looks up a 6-bit chunk.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0]                box,
  input  logic [DES_SBOX_IN_W-1:0]  chunk,
  output logic [DES_SBOX_OUT_W-1:0] result_c
);

  logic [5:0] idx_c;

  // Row comes from the outer bits b1,b6; column from the inner bits b2..b5.
  assign idx_c    = {chunk[5], chunk[0], chunk[4:1]};
  assign result_c = DES_SBOX_T[box][idx_c];

endmodule

// File: rtl/des_sbox_serial.sv
// Serial DES S-box layer: 48-bit keyed half-block in, 32-bit S1..S8 result out.
// LANES boxes are evaluated per cycle, so a block takes 8/LANES RUN cycles.
// Optional synchronous abort port 'flush' is built when DES_SBOX_FLUSH_EN is defined.
module des_sbox_serial
  import des_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:DES_EXP_W]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:DES_HALF_W] out_data
`ifdef DES_SBOX_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  localparam int unsigned STEPS  = DES_NUM_SBOX / LANES;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  // Only power-of-two lane counts up to eight divide the eight boxes evenly.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_serial: LANES must be 1, 2, 4 or 8");
  end

  des_sbox_state_e             state_q, state_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic                        out_valid_q, out_valid_d;
  logic [1:DES_EXP_W]          data_q;
  logic                        load_c;
  logic                        run_c;
  logic                        flush_c;
  logic [DES_SBOX_IN_W-1:0]    chunk_all_c [DES_NUM_SBOX];
  logic [DES_SBOX_OUT_W-1:0]   lane_res_c  [LANES];

`ifdef DES_SBOX_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Accept only in IDLE and never while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;

  // FSM state, step counter and output-valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; flush overrides any accept or output handshake.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    load_c      = 1'b0;
    run_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load_c  = 1'b1;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        run_c = 1'b1;
        if (step_q == LAST_STEP) begin
          step_d      = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        step_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
    if (flush_c) begin
      state_d     = IDLE;
      step_d      = '0;
      out_valid_d = 1'b0;
      load_c      = 1'b0;
      run_c       = 1'b0;
    end
  end

  // Input half-block is captured at accept so the source may change it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_c) begin
      data_q <= in_data;
    end
  end

  // Per-box input chunk and result nibble; a box's nibble updates only on its own step.
  for (genvar k = 0; k < int'(DES_NUM_SBOX); k++) begin : g_box
    localparam int unsigned       LANE = k % LANES;
    localparam logic [STEP_W-1:0] STEP = STEP_W'(k / LANES);

    logic [DES_SBOX_OUT_W-1:0] nib_q;

    assign chunk_all_c[k] = data_q[6*k+1 : 6*k+6];
    assign out_data[4*k+1 : 4*k+4] = nib_q;

    // Result nibble for this box; untouched nibbles keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        nib_q <= '0;
      end else if (run_c && (step_q == STEP)) begin
        nib_q <= lane_res_c[LANE];
      end
    end
  end

  // Lane l serves box step*LANES + l in the current RUN cycle.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [2:0]               box_c;
    logic [DES_SBOX_IN_W-1:0] chunk_c;

    assign box_c   = 3'(32'(step_q) * LANES + 32'(l));
    assign chunk_c = chunk_all_c[box_c];

    des_sbox_lane u_lane (
      .box      (box_c),
      .chunk    (chunk_c),
      .result_c (lane_res_c[l])
    );
  end

endmodule

// File: tb/tb_des_sbox_serial.sv
// Scoreboard bench for des_sbox_serial: four instances (LANES = 1, 2, 4, 8) share clock and reset.
// Directed vectors push expected data and latency; a negedge monitor pops on each output handshake.
module tb_des_sbox_serial;

  localparam int NI = 4;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [1:48]   in_data  [NI];
  logic [1:32]   out_data [NI];
  logic          flush_s;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  exp_t sb[$];

  int          acc_cyc  [NI];
  int          rise_cyc [NI];
  bit          prev_v   [NI];
  exp_t        mon_e;
  logic [31:0] mon_d;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    des_sbox_serial #(.LANES(1 << i)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_data   (in_data[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i])
`ifdef DES_SBOX_FLUSH_EN
      ,
      .flush     (flush_s)
`endif
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: track accept/rise cycles and compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        prev_v[i] = 1'b0;
      end else begin
        if (in_valid[i] && in_ready[i] && !flush_s) acc_cyc[i] = cyc + 1;
        if (out_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
        prev_v[i] = out_valid[i];
        if (out_valid[i] && out_ready[i] && !flush_s) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: inst %0d data %h with empty scoreboard", i, out_data[i]);
          end else begin
            mon_e = sb.pop_front();
            mon_d = out_data[i];
            chk("out_inst", 64'(i), 64'(mon_e.inst));
            chk("out_data", 64'(mon_d), 64'(mon_e.data));
            chk("latency", 64'(rise_cyc[i] - acc_cyc[i]), 64'(mon_e.lat));
          end
        end
      end
    end
  end

  task automatic send(input int inst, input logic [1:48] d, input logic [31:0] want, input bit push);
    int   n = 0;
    exp_t e;
    @(posedge clk); #1;
    in_valid[inst] = 1'b1;
    in_data[inst]  = d;
    @(negedge clk);
    while (!in_ready[inst] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(in_ready[inst]), 64'd1);
    if (in_ready[inst] && push) begin
      e.inst = inst;
      e.data = want;
      e.lat  = 8 >> inst;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[inst] = 1'b0;
    in_data[inst]  = {$urandom, 16'($urandom)};
  endtask

  task automatic wait_valid(input int inst);
    int n = 0;
    @(negedge clk);
    while (!out_valid[inst] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_rise", 64'(out_valid[inst]), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:48] d;
    int          n;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    flush_s   = 1'b0;
    for (int i = 0; i < NI; i++) in_data[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd0);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_out_data", 64'(out_data[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready[1]), 64'd1);

    // Zero input, LANES=2; in_ready back one cycle after the handshake.
    out_ready = '1;
    send(1, '0, 32'hEFA72C4D, 1'b1);
    wait_valid(1);
    @(negedge clk);
    chk("post_hs_in_ready", 64'(in_ready[1]), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid[1]), 64'd0);
    drain();

    // All ones across every lane count.
    for (int i = 0; i < NI; i++) begin
      send(i, '1, 32'hD9CE3DCB, 1'b1);
      drain();
    end

    // Only the S6 chunk set to 100001 (row 3, column 0).
    d = '0;
    d[31:36] = 6'b100001;
    send(1, d, 32'hEFA7244D, 1'b1);
    drain();

    // Backpressure in DONE with a second input offered meanwhile.
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    send(1, '0, 32'hEFA72C4D, 1'b1);
    wait_valid(1);
    @(posedge clk); #1;
    in_valid[1] = 1'b1;
    in_data[1]  = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid[1]), 64'd1);
      chk("hold_out_data", 64'(out_data[1]), 64'hEFA72C4D);
      chk("hold_in_ready", 64'(in_ready[1]), 64'd0);
    end
    begin
      exp_t e2;
      e2.inst = 1;
      e2.data = 32'hD9CE3DCB;
      e2.lat  = 4;
      sb.push_back(e2);
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("second_accept", 64'(in_ready[1]), 64'd1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    drain();

    // Asynchronous reset at step 3 of a LANES=1 block.
    send(0, '1, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrun_rst_out_data", 64'(out_data[0]), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    send(0, '0, 32'hEFA72C4D, 1'b1);
    drain();

`ifdef DES_SBOX_FLUSH_EN
    // Flush during RUN: back to IDLE, no output appears.
    send(1, '0, 32'h0, 1'b0);
    @(posedge clk); #1;
    flush_s = 1'b1;
    @(posedge clk); #1;
    flush_s = 1'b0;
    @(negedge clk);
    chk("flush_run_in_ready", 64'(in_ready[1]), 64'd1);
    chk("flush_run_out_valid", 64'(out_valid[1]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_run_quiet", 64'(out_valid[1]), 64'd0);
    end

    // Flush together with out_ready in DONE: output dropped, data kept.
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    send(1, '1, 32'h0, 1'b0);
    wait_valid(1);
    @(posedge clk); #1;
    flush_s      = 1'b1;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    flush_s = 1'b0;
    @(negedge clk);
    chk("flush_done_out_valid", 64'(out_valid[1]), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready[1]), 64'd1);
    chk("flush_keeps_data", 64'(out_data[1]), 64'hD9CE3DCB);
    send(1, d, 32'hEFA7244D, 1'b1);
    drain();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
